// File: rtl/clock_set_ctrl.sv
// -----------------------------------------------------------------------------
// clock_set_ctrl
//
// Front-panel sequencer for the digital clock. Debounced single-cycle key
// pulses drive a small edit FSM over BCD time and alarm digits.
//
//   IDLE      : mode -> time edit (preload from running time),
//               alarm -> alarm edit, alm_en -> toggle alarm enable.
//   TIME_EDIT : mode cycles hour/min/sec, inc bumps the field, ok -> COMMIT.
//   ALM_EDIT  : mode toggles hour/min, inc bumps the field, ok stores alarm.
//   COMMIT    : one-cycle set_time_finish strobe, then IDLE.
//
// An edit with no key activity for TIMEOUT_CYC cycles is abandoned without
// committing anything. An abandoned alarm edit reloads its buffer from the
// stored alarm so the next edit starts from the stored values.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   key_mode/alarm/inc/ok/alm_en single-cycle key pulses
//                               (priority ok > mode > alarm > inc > alm_en)
//   cur_*                       running time digits, used for preload
//   set_*                       time edit buffer, valid on set_time_finish
//   set_time_finish             one-cycle commit strobe
//   clock_*                     stored alarm digits
//   clock_en                    alarm enable
//   edit_field                  0 none, 1 hour, 2 min, 3 sec
//   edit_alarm                  high while editing the alarm
//   blink                       blink phase for the selected field
// -----------------------------------------------------------------------------
module clock_set_ctrl #(
   parameter int TIMEOUT_CYC = 1000,
   parameter int BLINK_HALF  = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       key_mode,
   input  logic       key_alarm,
   input  logic       key_inc,
   input  logic       key_ok,
   input  logic       key_alm_en,
   input  logic [3:0] cur_sec_ge,
   input  logic [3:0] cur_sec_shi,
   input  logic [3:0] cur_min_ge,
   input  logic [3:0] cur_min_shi,
   input  logic [3:0] cur_hour_ge,
   input  logic [3:0] cur_hour_shi,
   output logic [3:0] set_sec_ge,
   output logic [3:0] set_sec_shi,
   output logic [3:0] set_min_ge,
   output logic [3:0] set_min_shi,
   output logic [3:0] set_hour_ge,
   output logic [3:0] set_hour_shi,
   output logic       set_time_finish,
   output logic [3:0] clock_min_ge,
   output logic [3:0] clock_min_shi,
   output logic [3:0] clock_hour_ge,
   output logic [3:0] clock_hour_shi,
   output logic       clock_en,
   output logic [1:0] edit_field,
   output logic       edit_alarm,
   output logic       blink
);

   localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam int BL_W = (BLINK_HALF  > 1) ? $clog2(BLINK_HALF)  : 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
   localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_HALF - 1);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_TIME_EDIT = 2'd1,
      S_ALM_EDIT  = 2'd2,
      S_COMMIT    = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      F_NONE = 2'd0,
      F_HOUR = 2'd1,
      F_MIN  = 2'd2,
      F_SEC  = 2'd3
   } field_t;

   // Winning key of the cycle after priority resolution.
   typedef enum logic [2:0] {
      K_NONE,
      K_OK,
      K_MODE,
      K_ALARM,
      K_INC,
      K_ALM_EN
   } key_t;

   // ---------------------------------------------------------------------------
   // BCD increment helpers. Any digit pair outside the legal range (including
   // non-BCD digits) wraps straight to 00.
   // ---------------------------------------------------------------------------
   function automatic logic [7:0] inc_hour(input logic [3:0] shi, input logic [3:0] ge);
      logic [7:0] r;
      if (shi > 4'd2 || ge > 4'd9 || (shi == 4'd2 && ge >= 4'd3))
         r = 8'h00;
      else if (ge == 4'd9)
         r = {shi + 4'd1, 4'd0};
      else
         r = {shi, ge + 4'd1};
      return r;
   endfunction

   function automatic logic [7:0] inc_60(input logic [3:0] shi, input logic [3:0] ge);
      logic [7:0] r;
      if (shi > 4'd5 || ge > 4'd9 || (shi == 4'd5 && ge == 4'd9))
         r = 8'h00;
      else if (ge == 4'd9)
         r = {shi + 4'd1, 4'd0};
      else
         r = {shi, ge + 4'd1};
      return r;
   endfunction

   state_t          state, next_state;
   field_t          field_q, next_field;
   key_t            key;
   logic            any_key;
   logic [TO_W-1:0] to_cnt;
   logic [BL_W-1:0] bl_cnt;

   // Alarm edit buffer; mirrors clock_* whenever no alarm edit is in progress.
   logic [3:0] alm_min_ge, alm_min_shi, alm_hour_ge, alm_hour_shi;

   // Datapath actions decided by the FSM for this cycle.
   logic load_cur, inc_time, inc_alm, store_alm, restore_alm, toggle_en;
   logic force_blink, to_clr;

   // ---------------------------------------------------------------------------
   // Key priority: only the winning key acts, everything below it is dropped.
   // ---------------------------------------------------------------------------
   assign any_key = key_ok | key_mode | key_alarm | key_inc | key_alm_en;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves
      // it unassigned, which would infer a latch.
      key = K_NONE;
      if (key_ok)
         key = K_OK;
      else if (key_mode)
         key = K_MODE;
      else if (key_alarm)
         key = K_ALARM;
      else if (key_inc)
         key = K_INC;
      else if (key_alm_en)
         key = K_ALM_EN;
   end

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         field_q <= F_NONE;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop
         // samples the pre-edge values regardless of statement order.
         state   <= next_state;
         field_q <= next_field;
      end
   end

   // ---------------------------------------------------------------------------
   // Next state and datapath actions
   // ---------------------------------------------------------------------------
   always_comb begin
      next_state  = state;
      next_field  = field_q;
      load_cur    = 1'b0;
      inc_time    = 1'b0;
      inc_alm     = 1'b0;
      store_alm   = 1'b0;
      restore_alm = 1'b0;
      toggle_en   = 1'b0;
      force_blink = 1'b0;
      to_clr      = 1'b1;

      unique case (state)
         S_IDLE: begin
            unique case (key)
               K_MODE: begin
                  load_cur    = 1'b1;
                  next_field  = F_HOUR;
                  force_blink = 1'b1;
                  next_state  = S_TIME_EDIT;
               end
               K_ALARM: begin
                  next_field  = F_HOUR;
                  force_blink = 1'b1;
                  next_state  = S_ALM_EDIT;
               end
               K_ALM_EN: toggle_en = 1'b1;
               default: ;
            endcase
         end

         S_TIME_EDIT: begin
            unique case (key)
               K_OK: begin
                  next_field = F_NONE;
                  next_state = S_COMMIT;
               end
               K_MODE: begin
                  unique case (field_q)
                     F_HOUR:  next_field = F_MIN;
                     F_MIN:   next_field = F_SEC;
                     default: next_field = F_HOUR;
                  endcase
               end
               K_INC: begin
                  inc_time    = 1'b1;
                  force_blink = 1'b1;
               end
               K_NONE: begin
                  // Idle cycle: count towards abandoning the edit.
                  if (to_cnt == TO_LAST) begin
                     next_field = F_NONE;
                     next_state = S_IDLE;
                  end else begin
                     to_clr = 1'b0;
                  end
               end
               default: ;
            endcase
         end

         S_ALM_EDIT: begin
            unique case (key)
               K_OK: begin
                  store_alm  = 1'b1;
                  next_field = F_NONE;
                  next_state = S_IDLE;
               end
               K_MODE: next_field = (field_q == F_HOUR) ? F_MIN : F_HOUR;
               K_INC: begin
                  inc_alm     = 1'b1;
                  force_blink = 1'b1;
               end
               K_NONE: begin
                  if (to_cnt == TO_LAST) begin
                     restore_alm = 1'b1;
                     next_field  = F_NONE;
                     next_state  = S_IDLE;
                  end else begin
                     to_clr = 1'b0;
                  end
               end
               default: ;
            endcase
         end

         S_COMMIT: begin
            next_field = F_NONE;
            next_state = S_IDLE;
         end

         default: begin
            next_field = F_NONE;
            next_state = S_IDLE;
         end
      endcase
   end

   // Outputs derived straight from registered state, so none depend
   // combinationally on the key inputs.
   assign set_time_finish = (state == S_COMMIT);
   assign edit_alarm      = (state == S_ALM_EDIT);
   assign edit_field      = field_q;

   // ---------------------------------------------------------------------------
   // Inactivity timeout counter; held at zero unless idling inside an edit.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         to_cnt <= '0;
      else if (to_clr || any_key)
         to_cnt <= '0;
      else
         to_cnt <= to_cnt + 1'b1;
   end

   // ---------------------------------------------------------------------------
   // Blink: restarts "on" at edit entry and on every increment so the new
   // value is immediately visible, then free-runs while a field is selected.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blink  <= 1'b0;
         bl_cnt <= '0;
      end else if (force_blink) begin
         blink  <= 1'b1;
         bl_cnt <= '0;
      end else if (next_field == F_NONE) begin
         blink  <= 1'b0;
         bl_cnt <= '0;
      end else if (bl_cnt == BL_LAST) begin
         blink  <= ~blink;
         bl_cnt <= '0;
      end else begin
         bl_cnt <= bl_cnt + 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // Time edit buffer. Holds its last value in IDLE; the time block only
   // samples it on set_time_finish.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         set_sec_ge   <= 4'd0;
         set_sec_shi  <= 4'd0;
         set_min_ge   <= 4'd0;
         set_min_shi  <= 4'd0;
         set_hour_ge  <= 4'd0;
         set_hour_shi <= 4'd0;
      end else if (load_cur) begin
         set_sec_ge   <= cur_sec_ge;
         set_sec_shi  <= cur_sec_shi;
         set_min_ge   <= cur_min_ge;
         set_min_shi  <= cur_min_shi;
         set_hour_ge  <= cur_hour_ge;
         set_hour_shi <= cur_hour_shi;
      end else if (inc_time) begin
         unique case (field_q)
            F_HOUR:  {set_hour_shi, set_hour_ge} <= inc_hour(set_hour_shi, set_hour_ge);
            F_MIN:   {set_min_shi, set_min_ge}   <= inc_60(set_min_shi, set_min_ge);
            F_SEC:   {set_sec_shi, set_sec_ge}   <= inc_60(set_sec_shi, set_sec_ge);
            default: ;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Alarm edit buffer
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alm_min_ge   <= 4'd0;
         alm_min_shi  <= 4'd0;
         alm_hour_ge  <= 4'd0;
         alm_hour_shi <= 4'd0;
      end else if (restore_alm) begin
         alm_min_ge   <= clock_min_ge;
         alm_min_shi  <= clock_min_shi;
         alm_hour_ge  <= clock_hour_ge;
         alm_hour_shi <= clock_hour_shi;
      end else if (inc_alm) begin
         unique case (field_q)
            F_HOUR:  {alm_hour_shi, alm_hour_ge} <= inc_hour(alm_hour_shi, alm_hour_ge);
            F_MIN:   {alm_min_shi, alm_min_ge}   <= inc_60(alm_min_shi, alm_min_ge);
            default: ;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Stored alarm and enable
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clock_min_ge   <= 4'd0;
         clock_min_shi  <= 4'd0;
         clock_hour_ge  <= 4'd0;
         clock_hour_shi <= 4'd0;
         clock_en       <= 1'b0;
      end else begin
         if (store_alm) begin
            clock_min_ge   <= alm_min_ge;
            clock_min_shi  <= alm_min_shi;
            clock_hour_ge  <= alm_hour_ge;
            clock_hour_shi <= alm_hour_shi;
         end
         if (toggle_en)
            clock_en <= ~clock_en;
      end
   end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clock_set_ctrl
//
// Directed scenarios followed by random key traffic. Every cycle the DUT
// outputs are compared against a behavioural model that keeps time and alarm
// values as plain integers and applies the key rules with modulo arithmetic.
// -----------------------------------------------------------------------------
module tb_clock_set_ctrl;

   localparam int TIMEOUT_CYC = 1000;
   localparam int BLINK_HALF  = 4;

   // Key vector layout: {ok, mode, alarm, inc, alm_en}
   localparam logic [4:0] KOK  = 5'b10000;
   localparam logic [4:0] KMD  = 5'b01000;
   localparam logic [4:0] KAL  = 5'b00100;
   localparam logic [4:0] KIN  = 5'b00010;
   localparam logic [4:0] KEN  = 5'b00001;
   localparam logic [4:0] KNO  = 5'b00000;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       key_mode = 1'b0, key_alarm = 1'b0, key_inc = 1'b0;
   logic       key_ok = 1'b0, key_alm_en = 1'b0;
   logic [3:0] cur_sec_ge, cur_sec_shi, cur_min_ge, cur_min_shi, cur_hour_ge, cur_hour_shi;
   logic [3:0] set_sec_ge, set_sec_shi, set_min_ge, set_min_shi, set_hour_ge, set_hour_shi;
   logic       set_time_finish;
   logic [3:0] clock_min_ge, clock_min_shi, clock_hour_ge, clock_hour_shi;
   logic       clock_en;
   logic [1:0] edit_field;
   logic       edit_alarm;
   logic       blink;

   int cur_h = 0, cur_m = 0, cur_s = 0;

   assign cur_hour_shi = 4'(cur_h / 10);
   assign cur_hour_ge  = 4'(cur_h % 10);
   assign cur_min_shi  = 4'(cur_m / 10);
   assign cur_min_ge   = 4'(cur_m % 10);
   assign cur_sec_shi  = 4'(cur_s / 10);
   assign cur_sec_ge   = 4'(cur_s % 10);

   int checks = 0;
   int errors = 0;

   clock_set_ctrl #(.TIMEOUT_CYC(TIMEOUT_CYC), .BLINK_HALF(BLINK_HALF)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .key_mode        (key_mode),
      .key_alarm       (key_alarm),
      .key_inc         (key_inc),
      .key_ok          (key_ok),
      .key_alm_en      (key_alm_en),
      .cur_sec_ge      (cur_sec_ge),
      .cur_sec_shi     (cur_sec_shi),
      .cur_min_ge      (cur_min_ge),
      .cur_min_shi     (cur_min_shi),
      .cur_hour_ge     (cur_hour_ge),
      .cur_hour_shi    (cur_hour_shi),
      .set_sec_ge      (set_sec_ge),
      .set_sec_shi     (set_sec_shi),
      .set_min_ge      (set_min_ge),
      .set_min_shi     (set_min_shi),
      .set_hour_ge     (set_hour_ge),
      .set_hour_shi    (set_hour_shi),
      .set_time_finish (set_time_finish),
      .clock_min_ge    (clock_min_ge),
      .clock_min_shi   (clock_min_shi),
      .clock_hour_ge   (clock_hour_ge),
      .clock_hour_shi  (clock_hour_shi),
      .clock_en        (clock_en),
      .edit_field      (edit_field),
      .edit_alarm      (edit_alarm),
      .blink           (blink)
   );

   always #5 clk = ~clk;

   // ---------------------------------------------------------------------------
   // Reference model
   // ---------------------------------------------------------------------------
   typedef enum int {M_IDLE, M_TIME, M_ALM, M_COMMIT} mode_t;

   mode_t m_mode;
   int    m_field;     // 0 none, 1 hour, 2 min, 3 sec
   int    m_set[3];    // hour, min, sec as integers
   int    m_alm[2];    // alarm edit buffer: hour, min
   int    m_clk[2];    // stored alarm: hour, min
   int    m_en;
   int    m_idle;      // cycles without any key inside an edit
   int    m_t;         // cycles since the blink was last forced on

   function automatic int bump(input int v, input int lim);
      return (v >= lim - 1) ? 0 : v + 1;
   endfunction

   task automatic model_reset();
      m_mode  = M_IDLE;
      m_field = 0;
      for (int i = 0; i < 3; i++) m_set[i] = 0;
      for (int i = 0; i < 2; i++) begin
         m_alm[i] = 0;
         m_clk[i] = 0;
      end
      m_en   = 0;
      m_idle = 0;
      m_t    = 0;
   endtask

   task automatic model_edge(input logic [4:0] k);
      int win;
      bit forced;
      bit any;
      forced = 1'b0;
      any    = |k;
      if (k[4])      win = 1;   // ok
      else if (k[3]) win = 2;   // mode
      else if (k[2]) win = 3;   // alarm
      else if (k[1]) win = 4;   // inc
      else if (k[0]) win = 5;   // alarm enable
      else           win = 0;

      case (m_mode)
         M_COMMIT: begin
            m_mode  = M_IDLE;
            m_field = 0;
         end
         M_IDLE: begin
            if (win == 2) begin
               m_set[0] = cur_h;
               m_set[1] = cur_m;
               m_set[2] = cur_s;
               m_field  = 1;
               m_mode   = M_TIME;
               m_idle   = 0;
               forced   = 1'b1;
            end else if (win == 3) begin
               m_field = 1;
               m_mode  = M_ALM;
               m_idle  = 0;
               forced  = 1'b1;
            end else if (win == 5) begin
               m_en = 1 - m_en;
            end
         end
         M_TIME: begin
            if (any) begin
               m_idle = 0;
               if (win == 1) begin
                  m_mode  = M_COMMIT;
                  m_field = 0;
               end else if (win == 2) begin
                  m_field = m_field % 3 + 1;
               end else if (win == 4) begin
                  m_set[m_field-1] = bump(m_set[m_field-1], (m_field == 1) ? 24 : 60);
                  forced = 1'b1;
               end
            end else begin
               m_idle++;
               if (m_idle == TIMEOUT_CYC) begin
                  m_mode  = M_IDLE;
                  m_field = 0;
               end
            end
         end
         M_ALM: begin
            if (any) begin
               m_idle = 0;
               if (win == 1) begin
                  m_clk[0] = m_alm[0];
                  m_clk[1] = m_alm[1];
                  m_mode   = M_IDLE;
                  m_field  = 0;
               end else if (win == 2) begin
                  m_field = 3 - m_field;
               end else if (win == 4) begin
                  m_alm[m_field-1] = bump(m_alm[m_field-1], (m_field == 1) ? 24 : 60);
                  forced = 1'b1;
               end
            end else begin
               m_idle++;
               if (m_idle == TIMEOUT_CYC) begin
                  m_alm[0] = m_clk[0];
                  m_alm[1] = m_clk[1];
                  m_mode   = M_IDLE;
                  m_field  = 0;
               end
            end
         end
         default: ;
      endcase

      if (m_mode == M_TIME || m_mode == M_ALM)
         m_t = forced ? 0 : m_t + 1;
      else
         m_t = 0;
   endtask

   function automatic int exp_blink();
      if (m_mode == M_TIME || m_mode == M_ALM)
         return ((m_t / BLINK_HALF) % 2 == 0) ? 1 : 0;
      return 0;
   endfunction

   // ---------------------------------------------------------------------------
   // Checking
   // ---------------------------------------------------------------------------
   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all();
      check("set_time_finish", 8'(set_time_finish), 8'(m_mode == M_COMMIT));
      check("edit_field",      8'(edit_field),      8'(m_field));
      check("edit_alarm",      8'(edit_alarm),      8'(m_mode == M_ALM));
      check("clock_en",        8'(clock_en),        8'(m_en));
      check("blink",           8'(blink),           8'(exp_blink()));
      check("set_hour_shi",    8'(set_hour_shi),    8'(m_set[0] / 10));
      check("set_hour_ge",     8'(set_hour_ge),     8'(m_set[0] % 10));
      check("set_min_shi",     8'(set_min_shi),     8'(m_set[1] / 10));
      check("set_min_ge",      8'(set_min_ge),      8'(m_set[1] % 10));
      check("set_sec_shi",     8'(set_sec_shi),     8'(m_set[2] / 10));
      check("set_sec_ge",      8'(set_sec_ge),      8'(m_set[2] % 10));
      check("clock_hour_shi",  8'(clock_hour_shi),  8'(m_clk[0] / 10));
      check("clock_hour_ge",   8'(clock_hour_ge),   8'(m_clk[0] % 10));
      check("clock_min_shi",   8'(clock_min_shi),   8'(m_clk[1] / 10));
      check("clock_min_ge",    8'(clock_min_ge),    8'(m_clk[1] % 10));
   endtask

   // One clock cycle: present keys on the falling edge, let the rising edge
   // sample them, then compare just after the edge.
   task automatic step(input logic [4:0] k);
      @(negedge clk);
      {key_ok, key_mode, key_alarm, key_inc, key_alm_en} = k;
      @(posedge clk);
      model_edge(k);
      #1;
      {key_ok, key_mode, key_alarm, key_inc, key_alm_en} = KNO;
      check_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(KNO);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic set_cur(input int h, input int m, input int s);
      cur_h = h;
      cur_m = m;
      cur_s = s;
   endtask

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      logic [4:0] k;
      model_reset();
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 check_all();
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);

      // Alarm enable toggles in IDLE.
      step(KEN);
      step(KEN);
      idle(1);

      // Time edit: 12:34:56, hour +3, commit.
      set_cur(12, 34, 56);
      step(KMD);
      step(KIN);
      step(KIN);
      step(KIN);
      step(KOK);
      idle(3);

      // Hour 22 -> 00 and minute 58 -> 00 without touching the hour.
      set_cur(22, 58, 7);
      step(KMD);
      step(KIN);
      step(KIN);
      step(KMD);
      step(KIN);
      step(KIN);
      step(KOK);
      idle(2);

      // Alarm edit: minute +5, store; no strobe.
      step(KAL);
      step(KMD);
      repeat (5) step(KIN);
      step(KOK);
      idle(2);

      // Keys that IDLE ignores, including ok winning over mode.
      step(KIN);
      step(KOK);
      step(KOK | KMD);
      idle(1);

      // Time edit abandoned by inactivity.
      set_cur(8, 9, 10);
      step(KMD);
      idle(TIMEOUT_CYC + 3);

      // Alarm edit abandoned: stored alarm unchanged, buffer reloaded.
      step(KAL);
      step(KIN);
      step(KIN);
      idle(TIMEOUT_CYC + 3);
      step(KAL);
      step(KOK);
      idle(1);

      // Out-of-range preload hour 25 wraps to 00.
      set_cur(25, 59, 59);
      step(KMD);
      step(KIN);
      step(KMD);
      step(KMD);
      step(KIN);
      step(KOK);
      idle(2);

      // ok and inc together: commit the unincremented value.
      set_cur(9, 0, 0);
      step(KMD);
      step(KOK | KIN);
      idle(2);

      // Reset in the middle of a time edit.
      set_cur(17, 45, 30);
      step(KMD);
      step(KIN);
      apply_reset();
      idle(3);

      // Random key traffic.
      for (int i = 0; i < 800; i++) begin
         set_cur($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
         for (int b = 0; b < 5; b++)
            k[b] = ($urandom_range(0, 5) == 0);
         step(k);
      end
      idle(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
